// File: rtl/pipelined_rca_addsub_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   ADD / SUB     : values of the 'sub' mode input
//   chunk_width() : bits resolved per pipeline stage
//   width_ok()    : legality of a WIDTH/STAGES pair, checked at elaboration
package pipelined_rca_addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned stages);
    return (stages != 0) && (width != 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_rca_addsub_if.sv
// Operand/result bus of the pipelined adder/subtractor.
//   master : operand source and result consumer (drives operands, out_ready)
//   slave  : the adder (drives in_ready and the result beat)
interface pipelined_rca_addsub_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] tag_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, cin, sub, tag_in, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, tag_out
  );

  modport slave (
    input  in_valid, a, b, cin, sub, tag_in, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, tag_out
  );

endinterface

// File: rtl/pipelined_rca_addsub_rca_chunk.sv
// Combinational W-bit ripple-carry adder built from a chain of full adders.
//   a, b     : addends
//   cin      : carry into bit 0
//   s        : sum
//   cout     : carry out of bit W-1
//   c_msb_in : carry into bit W-1 (xor with cout gives signed overflow)
module rca_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  always_comb begin
    logic carry;
    carry    = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_in = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks, one chunk
// resolved per cycle with the carry registered between stages. Results carry cout, signed
// overflow, zero flag and the caller's tag, in issue order, STAGES cycles after acceptance.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, discards everything in flight
//   bus : slave side of pipelined_rca_addsub_if (operand and result valid/ready beats)
module pipelined_rca_addsub
  import pipelined_rca_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_rca_addsub_if.slave bus
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_width_check
    $error("pipelined_rca_addsub: WIDTH must be a nonzero multiple of STAGES");
  end

  logic adv;

  // Per-stage inputs: stage 0 sees the bus, stage k sees the registers of stage k-1.
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] carry_in;
  logic [TAG_W-1:0]  tag_st [STAGES];
  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  bp_in  [STAGES];
  logic [WIDTH-1:0]  sum_in [STAGES];

  logic [WIDTH-1:0]  chunk_s;
  logic [STAGES-1:0] chunk_co;
  logic              chunk_cm [STAGES];

  // Stage registers; index STAGES-1 is the output stage.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] carry_q;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  bp_q  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  always_comb begin
    v_in[0]     = bus.in_valid;
    tag_st[0]   = bus.tag_in;
    a_in[0]     = bus.a;
    bp_in[0]    = (bus.sub == SUB) ? ~bus.b : bus.b;
    carry_in[0] = (bus.sub == ADD) ? bus.cin : 1'b1;
    sum_in[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]     = v_q[k-1];
      tag_st[k]   = tag_q[k-1];
      a_in[k]     = a_q[k-1];
      bp_in[k]    = bp_q[k-1];
      carry_in[k] = carry_q[k-1];
      sum_in[k]   = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .a        (a_in[k][k*CHUNK +: CHUNK]),
      .b        (bp_in[k][k*CHUNK +: CHUNK]),
      .cin      (carry_in[k]),
      .s        (chunk_s[k*CHUNK +: CHUNK]),
      .cout     (chunk_co[k]),
      .c_msb_in (chunk_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]                  = sum_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = chunk_s[k*CHUNK +: CHUNK];
    end
    // Flags come from the top chunk and the fully accumulated sum.
    ovf_d  = chunk_cm[STAGES-1] ^ chunk_co[STAGES-1];
    zero_d = (sum_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k] <= '0;
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      v_q     <= v_in;
      carry_q <= chunk_co;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k] <= tag_st[k];
        a_q[k]   <= a_in[k];
        bp_q[k]  <= bp_in[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // The whole pipe moves in lockstep; it only freezes on a stalled valid result.
  assign adv          = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.s         = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.tag_out   = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
module tb_pipelined_rca_addsub;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_rca_addsub_if #(.WIDTH(32), .TAG_W(4)) bus ();
  pipelined_rca_addsub_if #(.WIDTH(16), .TAG_W(4)) bus1 ();

  pipelined_rca_addsub #(
    .WIDTH (32),
    .STAGES(4),
    .TAG_W (4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pipelined_rca_addsub #(
    .WIDTH (16),
    .STAGES(1),
    .TAG_W (4)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  tag;
  } beat_t;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t model(input beat_t bt);
    logic [31:0] bp;
    logic [32:0] full;
    res_t        r;
    bp     = bt.sub ? ~bt.b : bt.b;
    full   = {1'b0, bt.a} + {1'b0, bp} + (bt.sub ? 33'd1 : {32'd0, bt.cin});
    r.s    = full[31:0];
    r.cout = full[32];
    r.ovf  = (bt.a[31] == bp[31]) && (r.s[31] != bt.a[31]);
    r.zero = (r.s == 32'd0);
    r.tag  = bt.tag;
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.s    = bus.s;
    r.cout = bus.cout;
    r.ovf  = bus.ovf;
    r.zero = bus.zero;
    r.tag  = bus.tag_out;
    return r;
  endfunction

  function automatic beat_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic sub, input logic [3:0] tag);
    beat_t bt;
    bt.a = a; bt.b = b; bt.cin = cin; bt.sub = sub; bt.tag = tag;
    return bt;
  endfunction

  function automatic res_t mr(input logic [31:0] s, input logic cout, input logic ovf,
                              input logic zero, input logic [3:0] tag);
    res_t r;
    r.s = s; r.cout = cout; r.ovf = ovf; r.zero = zero; r.tag = tag;
    return r;
  endfunction

  task automatic drive(input beat_t bt, input logic v);
    bus.in_valid = v;
    bus.a        = bt.a;
    bus.b        = bt.b;
    bus.cin      = bt.cin;
    bus.sub      = bt.sub;
    bus.tag_in   = bt.tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(mk(32'd0, 32'd0, 1'b0, 1'b0, 4'd0), 1'b0);
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.cin       = 1'b0;
    bus1.sub       = 1'b0;
    bus1.tag_in    = '0;
    bus1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (observed() !== res_t'(0)) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", observed());
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  // One beat into an idle pipe; result must appear exactly 4 cycles later.
  task automatic test_single(input beat_t bt, input res_t ex, input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(bt, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", name, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_early: out_valid got %b expected 0 at cycle 3", name,
                         bus.out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_latency: out_valid got %b expected 1 at cycle 4", name,
                         bus.out_valid);
    end
    checks++;
    if (observed() !== ex) begin
      errors++; $display("FAIL %s_result: got %h expected %h", name, observed(), ex);
    end
  endtask

  task automatic test_back_to_back();
    beat_t stim[8];
    res_t  e;
    int    idx = 0;
    int    got = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      stim[i] = mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'(i));
    end
    for (int t = 0; t < 40 && got < 8; t++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (idx < 8) drive(stim[idx], 1'b1);
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got %h expected no beat", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            errors++; $display("FAIL b2b_result: got %h expected %h", observed(), e);
          end
        end
        checks++;
        if (t != 4 + got) begin
          errors++; $display("FAIL b2b_timing: beat %0d at cycle %0d expected %0d", got, t,
                             4 + got);
        end
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp_q.push_back(model(stim[idx]));
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL b2b_count: got %0d beats expected 8", got);
    end
  endtask

  task automatic test_stall();
    beat_t stim[6];
    res_t  e;
    res_t  held;
    int    idx = 0;
    int    got = 0;
    int    extra = 0;
    exp_q.delete();
    held = '0;
    for (int i = 0; i < 6; i++) begin
      stim[i] = mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'(8 + i));
    end
    for (int t = 0; t < 60 && extra < 5; t++) begin
      @(negedge clk);
      bus.out_ready = (t >= 7);
      if (idx < 6) drive(stim[idx], 1'b1);
      else bus.in_valid = 1'b0;
      #1;
      if (t == 4) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_full: out_valid %b in_ready %b expected 1 0",
                             bus.out_valid, bus.in_ready);
        end
        held = observed();
      end
      if (t == 5 || t == 6) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== held) begin
          errors++; $display("FAIL stall_stable: got %b/%h expected 1/%h", bus.out_valid,
                             observed(), held);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_duplicate: got %h expected no beat", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            errors++; $display("FAIL stall_result: got %h expected %h", observed(), e);
          end
          got++;
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp_q.push_back(model(stim[idx]));
        idx++;
      end
      if (got == 6) extra++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_delivery: got %0d beats, %0d pending, expected 6, 0", got,
                         exp_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    exp_q.delete();
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (t < 3) drive(mk(32'(t + 100), 32'd7, 1'b0, 1'b0, 4'(t + 1)), 1'b1);
      else bus.in_valid = 1'b0;
    end
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_prefill: out_valid got %b expected 1", bus.out_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async: out_valid got %b expected 0", bus.out_valid);
    end
    checks++;
    if (observed() !== res_t'(0)) begin
      errors++; $display("FAIL rst_async_outputs: got %h expected 0", observed());
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_stale: out_valid got %b expected 0 (tag %h)",
                           bus.out_valid, bus.tag_out);
      end
    end
    test_single(mk(32'd5, 32'd3, 1'b0, 1'b1, 4'd9), mr(32'd2, 1'b1, 1'b0, 1'b0, 4'd9),
                "post_rst");
  endtask

  task automatic test_stages1();
    @(negedge clk);
    bus1.out_ready = 1'b1;
    bus1.a         = 16'h1234;
    bus1.b         = 16'hEDCC;
    bus1.cin       = 1'b0;
    bus1.sub       = 1'b0;
    bus1.tag_in    = 4'd7;
    bus1.in_valid  = 1'b1;
    #1;
    checks++;
    if (bus1.in_ready !== 1'b1) begin
      errors++; $display("FAIL s1_in_ready: got %b expected 1", bus1.in_ready);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #1;
    checks++;
    if (bus1.out_valid !== 1'b1) begin
      errors++; $display("FAIL s1_latency: out_valid got %b expected 1", bus1.out_valid);
    end
    checks++;
    if ({bus1.s, bus1.cout, bus1.ovf, bus1.zero, bus1.tag_out} !== {16'h0000, 3'b101, 4'd7})
    begin
      errors++; $display("FAIL s1_result: got s=%h c=%b v=%b z=%b t=%h expected 0000 1 0 1 7",
                         bus1.s, bus1.cout, bus1.ovf, bus1.zero, bus1.tag_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus1.out_valid !== 1'b0) begin
      errors++; $display("FAIL s1_drain: out_valid got %b expected 0", bus1.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd3),
                mr(32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'd3), "add_wrap");
    test_single(mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd5),
                mr(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 4'd5), "sub_ovf");
    test_single(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd6),
                mr(32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd6), "add_ovf");
    test_single(mk(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 4'd2),
                mr(32'h0000_0100, 1'b0, 1'b0, 1'b0, 4'd2), "add_cin");
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_stages1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
